// File: rtl/nx_stream_gearbox.sv
// Host AXI4-stream <-> fabric message gearbox: unpacks wide inbound beats into messages and
// packs outbound messages into framed wide beats. Optional counters under NX_GEARBOX_COUNTERS_EN.
module nx_stream_gearbox #(
   parameter int AXI4_DATA_WIDTH = 128,
   parameter int MSG_WIDTH       = 32,
   parameter int PKT_BEATS       = 16,
   parameter int FLUSH_CYCLES    = 64
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic [AXI4_DATA_WIDTH-1:0] i_in_tdata,
   input  logic                       i_in_tlast,
   input  logic                       i_in_tvalid,
   output logic                       o_in_tready,
   output logic [MSG_WIDTH-1:0]       o_msg_data,
   output logic                       o_msg_valid,
   input  logic                       i_msg_ready,
   input  logic [MSG_WIDTH-1:0]       i_msg_data,
   input  logic                       i_msg_valid,
   output logic                       o_msg_ready,
   output logic [AXI4_DATA_WIDTH-1:0] o_out_tdata,
   output logic                       o_out_tlast,
   output logic                       o_out_tvalid,
`ifdef NX_GEARBOX_COUNTERS_EN
   input  logic                       i_out_tready,
   output logic [31:0]                o_cnt_in_pkts,
   output logic [31:0]                o_cnt_out_pkts,
   output logic [31:0]                o_cnt_drops
`else
   input  logic                       i_out_tready
`endif
);

   localparam int SLOTS = AXI4_DATA_WIDTH / MSG_WIDTH;
   localparam int CW    = $clog2(SLOTS + 1);
   localparam int BW    = $clog2(PKT_BEATS + 1);
   localparam int TW    = $clog2(FLUSH_CYCLES + 1);
   localparam logic [CW-1:0]    FILL_FULL  = CW'(SLOTS);
   localparam logic [CW-1:0]    FILL_LAST  = CW'(SLOTS - 1);
   localparam logic [BW-1:0]    PKT_LAST   = BW'(PKT_BEATS - 1);
   localparam logic [TW-1:0]    FLUSH_LAST = TW'(FLUSH_CYCLES - 1);
   localparam logic [SLOTS-1:0] MASK_ONE   = {{(SLOTS-1){1'b0}}, 1'b1};

   function automatic logic [SLOTS-1:0] slot_flags(input logic [AXI4_DATA_WIDTH-1:0] beat);
      for (int k = 0; k < SLOTS; k++) begin
         slot_flags[k] = beat[k*MSG_WIDTH + MSG_WIDTH - 1];
      end
   endfunction

   function automatic logic [MSG_WIDTH-1:0] lowest_slot(input logic [AXI4_DATA_WIDTH-1:0] beat,
                                                        input logic [SLOTS-1:0] mask);
      lowest_slot = '0;
      for (int k = SLOTS - 1; k >= 0; k--) begin
         if (mask[k]) begin
            lowest_slot = beat[k*MSG_WIDTH +: MSG_WIDTH];
         end
      end
   endfunction

   logic [AXI4_DATA_WIDTH-1:0] beat_q, beat_d;
   logic [SLOTS-1:0]           mask_q, mask_d, mask_left_s, in_flags_s;
   logic [MSG_WIDTH-1:0]       msg_data_q, msg_data_d;
   logic                       msg_valid_q, msg_valid_d;
   logic                       msg_hs_s, in_ready_s, in_hs_s, in_drop_s;

   // Inbound unpack: a slot leaves the mask on each fabric handshake; a new beat may enter the same cycle.
   always_comb begin
      msg_hs_s    = msg_valid_q & i_msg_ready;
      mask_left_s = msg_hs_s ? (mask_q & (mask_q - MASK_ONE)) : mask_q;
      in_ready_s  = (mask_left_s == '0);
      in_hs_s     = i_in_tvalid & in_ready_s;
      in_flags_s  = slot_flags(i_in_tdata);
      in_drop_s   = in_hs_s & (in_flags_s == '0);
      if (in_hs_s) begin
         beat_d = i_in_tdata;
         mask_d = in_flags_s;
      end else begin
         beat_d = beat_q;
         mask_d = mask_left_s;
      end
      msg_data_d  = lowest_slot(beat_d, mask_d);
      msg_valid_d = (mask_d != '0);
   end

   // Inbound state registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         beat_q      <= '0;
         mask_q      <= '0;
         msg_data_q  <= '0;
         msg_valid_q <= 1'b0;
      end else begin
         beat_q      <= beat_d;
         mask_q      <= mask_d;
         msg_data_q  <= msg_data_d;
         msg_valid_q <= msg_valid_d;
      end
   end

   assign o_in_tready = in_ready_s;
   assign o_msg_data  = msg_data_q;
   assign o_msg_valid = msg_valid_q;

   logic [AXI4_DATA_WIDTH-1:0] acc_q, acc_d, out_data_q, out_data_d;
   logic [CW-1:0]              fill_q, fill_d;
   logic [BW-1:0]              beat_cnt_q, beat_cnt_d, cnt_eff_s;
   logic [TW-1:0]              timer_q, timer_d;
   logic                       out_valid_q, out_valid_d, out_last_q, out_last_d;
   logic                       out_hs_s, out_free_s, acc_full_s, msg_ready_s;
   logic                       om_hs_s, om_take_s, om_drop_s, pkt_end_s;

   // Outbound pack: the completing message may bypass straight into the output register.
   always_comb begin
      out_hs_s    = out_valid_q & i_out_tready;
      out_free_s  = ~out_valid_q | i_out_tready;
      acc_full_s  = (fill_q == FILL_FULL);
      msg_ready_s = ~acc_full_s | out_free_s;
      om_hs_s     = i_msg_valid & msg_ready_s;
      om_take_s   = om_hs_s & i_msg_data[MSG_WIDTH-1];
      om_drop_s   = om_hs_s & ~i_msg_data[MSG_WIDTH-1];
      if (out_hs_s) begin
         cnt_eff_s = out_last_q ? '0 : beat_cnt_q + BW'(1);
      end else begin
         cnt_eff_s = beat_cnt_q;
      end
      pkt_end_s   = (cnt_eff_s == PKT_LAST);
      beat_cnt_d  = cnt_eff_s;
      acc_d       = acc_q;
      fill_d      = fill_q;
      timer_d     = timer_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      out_valid_d = out_valid_q & ~out_hs_s;
      if (acc_full_s) begin
         timer_d = '0;
         if (out_free_s) begin
            out_data_d  = acc_q;
            out_last_d  = pkt_end_s;
            out_valid_d = 1'b1;
            acc_d       = '0;
            fill_d      = '0;
            if (om_take_s) begin
               acc_d[MSG_WIDTH-1:0] = i_msg_data;
               fill_d               = CW'(1);
            end
         end else begin
            fill_d = fill_q;
         end
      end else if (om_take_s && (fill_q == FILL_LAST)) begin
         timer_d = '0;
         acc_d[(SLOTS-1)*MSG_WIDTH +: MSG_WIDTH] = i_msg_data;
         if (out_free_s) begin
            out_data_d  = acc_d;
            out_last_d  = pkt_end_s;
            out_valid_d = 1'b1;
            acc_d       = '0;
            fill_d      = '0;
         end else begin
            fill_d = FILL_FULL;
         end
      end else if (om_take_s) begin
         timer_d = '0;
         fill_d  = fill_q + CW'(1);
         for (int k = 0; k < SLOTS - 1; k++) begin
            if (fill_q == CW'(k)) begin
               acc_d[k*MSG_WIDTH +: MSG_WIDTH] = i_msg_data;
            end
         end
      end else if (om_hs_s || (fill_q == '0)) begin
         timer_d = '0;
      end else if (timer_q == FLUSH_LAST) begin
         // Timer parks at its last count until the output register can take the flush beat.
         if (out_free_s) begin
            out_data_d  = acc_q;
            out_last_d  = 1'b1;
            out_valid_d = 1'b1;
            acc_d       = '0;
            fill_d      = '0;
            timer_d     = '0;
         end else begin
            timer_d = timer_q;
         end
      end else begin
         timer_d = timer_q + TW'(1);
      end
   end

   // Outbound state registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         acc_q       <= '0;
         fill_q      <= '0;
         timer_q     <= '0;
         beat_cnt_q  <= '0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         fill_q      <= fill_d;
         timer_q     <= timer_d;
         beat_cnt_q  <= beat_cnt_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign o_msg_ready  = msg_ready_s;
   assign o_out_tdata  = out_data_q;
   assign o_out_tlast  = out_last_q;
   assign o_out_tvalid = out_valid_q;

`ifdef NX_GEARBOX_COUNTERS_EN
   logic [31:0] cnt_in_q, cnt_out_q, cnt_drop_q;

   // Statistics counters; simultaneous inbound and outbound drops count once.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt_in_q   <= '0;
         cnt_out_q  <= '0;
         cnt_drop_q <= '0;
      end else begin
         cnt_in_q   <= cnt_in_q + {31'd0, in_hs_s & i_in_tlast};
         cnt_out_q  <= cnt_out_q + {31'd0, out_hs_s & out_last_q};
         cnt_drop_q <= cnt_drop_q + {31'd0, in_drop_s | om_drop_s};
      end
   end

   assign o_cnt_in_pkts  = cnt_in_q;
   assign o_cnt_out_pkts = cnt_out_q;
   assign o_cnt_drops    = cnt_drop_q;
`else
   logic unused_stats_s;
   assign unused_stats_s = i_in_tlast ^ in_drop_s ^ om_drop_s;
`endif

endmodule

// File: tb/tb_nx_stream_gearbox.sv
// Directed bench for nx_stream_gearbox at default parameters (4 slots, 16-beat packets, 64-cycle flush).
module tb_nx_stream_gearbox;

   logic         i_clk = 1'b0;
   logic         i_rst;
   logic [127:0] i_in_tdata;
   logic         i_in_tlast, i_in_tvalid, o_in_tready;
   logic [31:0]  o_msg_data, i_msg_data;
   logic         o_msg_valid, i_msg_ready, i_msg_valid, o_msg_ready;
   logic [127:0] o_out_tdata;
   logic         o_out_tlast, o_out_tvalid, i_out_tready;
`ifdef NX_GEARBOX_COUNTERS_EN
   logic [31:0]  o_cnt_in_pkts, o_cnt_out_pkts, o_cnt_drops;
`endif

   int           n_vec = 0;
   int           n_err = 0;
   int           nb;
   int           nv;
   logic [127:0] exp_b;
   logic [127:0] held_b;

   always #5 i_clk = ~i_clk;

   nx_stream_gearbox dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_in_tdata   (i_in_tdata),
      .i_in_tlast   (i_in_tlast),
      .i_in_tvalid  (i_in_tvalid),
      .o_in_tready  (o_in_tready),
      .o_msg_data   (o_msg_data),
      .o_msg_valid  (o_msg_valid),
      .i_msg_ready  (i_msg_ready),
      .i_msg_data   (i_msg_data),
      .i_msg_valid  (i_msg_valid),
      .o_msg_ready  (o_msg_ready),
      .o_out_tdata  (o_out_tdata),
      .o_out_tlast  (o_out_tlast),
      .o_out_tvalid (o_out_tvalid),
`ifdef NX_GEARBOX_COUNTERS_EN
      .i_out_tready   (i_out_tready),
      .o_cnt_in_pkts  (o_cnt_in_pkts),
      .o_cnt_out_pkts (o_cnt_out_pkts),
      .o_cnt_drops    (o_cnt_drops)
`else
      .i_out_tready (i_out_tready)
`endif
   );

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic send_msg(input logic [31:0] d);
      i_msg_valid = 1'b1;
      i_msg_data  = d;
      tick();
      i_msg_valid = 1'b0;
   endtask

   initial begin
      i_rst = 1'b1;  i_in_tdata = '0; i_in_tlast = 1'b0; i_in_tvalid = 1'b0;
      i_msg_ready = 1'b0; i_msg_data = '0; i_msg_valid = 1'b0; i_out_tready = 1'b0;
      repeat (3) tick();
      i_rst = 1'b0;
      #1;
      chk("rst_in_tready", o_in_tready, 1);
      chk("rst_msg_valid", o_msg_valid, 0);
      chk("rst_msg_data", o_msg_data, 0);
      chk("rst_msg_ready", o_msg_ready, 1);
      chk("rst_out_tvalid", o_out_tvalid, 0);
      chk("rst_out_tdata", o_out_tdata, 0);
      chk("rst_out_tlast", o_out_tlast, 0);
`ifdef NX_GEARBOX_COUNTERS_EN
      chk("rst_cnt_in", o_cnt_in_pkts, 0);
      chk("rst_cnt_drops", o_cnt_drops, 0);
`endif

      // Inbound unpack, slot 1 carries a clear flag and is skipped.
      i_msg_ready = 1'b1;
      i_in_tdata  = {32'h8000_0004, 32'h8000_0003, 32'h0000_0002, 32'h8000_0001};
      i_in_tlast  = 1'b1;
      i_in_tvalid = 1'b1;
      tick();
      i_in_tvalid = 1'b0;
      i_in_tlast  = 1'b0;
      chk("in_first_valid", o_msg_valid, 1);
      chk("in_first_data", o_msg_data, 32'h8000_0001);
      tick();
      chk("in_second_data", o_msg_data, 32'h8000_0003);
      chk("in_tready_busy", o_in_tready, 0);
      tick();
      chk("in_third_data", o_msg_data, 32'h8000_0004);
      chk("in_tready_last", o_in_tready, 1);
      i_in_tdata  = {32'h0000_0000, 32'h0000_0000, 32'h8000_0005, 32'h0000_0009};
      i_in_tvalid = 1'b1;
      tick();
      chk("in_b2b_valid", o_msg_valid, 1);
      chk("in_b2b_data", o_msg_data, 32'h8000_0005);
      i_in_tdata = {32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 32'h0000_0004};
      tick();
      i_in_tvalid = 1'b0;
      chk("in_empty_drop", o_msg_valid, 0);
      chk("in_tready_idle", o_in_tready, 1);

      // Outbound full beat with a flag-clear message discarded in the middle.
      send_msg(32'h8000_00A0);
      send_msg(32'h8000_00A1);
      send_msg(32'h0000_00FF);
      send_msg(32'h8000_00A2);
      chk("out_not_yet", o_out_tvalid, 0);
      send_msg(32'h8000_00A3);
      chk("out_full_valid", o_out_tvalid, 1);
      chk("out_full_data", o_out_tdata, {32'h8000_00A3, 32'h8000_00A2, 32'h8000_00A1, 32'h8000_00A0});
      chk("out_full_last", o_out_tlast, 0);
      i_out_tready = 1'b1;
      tick();
      chk("out_full_drained", o_out_tvalid, 0);

      // Flush of a partial beat after 64 idle cycles.
      send_msg(32'h8000_00B0);
      send_msg(32'h8000_00B1);
      repeat (63) tick();
      chk("flush_early", o_out_tvalid, 0);
      tick();
      chk("flush_valid", o_out_tvalid, 1);
      chk("flush_data", o_out_tdata, {32'h0, 32'h0, 32'h8000_00B1, 32'h8000_00B0});
      chk("flush_last", o_out_tlast, 1);
      tick();
      chk("flush_drained", o_out_tvalid, 0);

      // Packet framing: 64 continuous messages, tlast on beat 16 only.
      nb = 0;
      for (int c = 0; c < 70; c++) begin
         i_msg_valid = (c < 64);
         i_msg_data  = 32'h8000_0100 + 32'(c);
         tick();
         if (o_out_tvalid) begin
            exp_b = {32'h8000_0103 + 32'(4*nb), 32'h8000_0102 + 32'(4*nb),
                     32'h8000_0101 + 32'(4*nb), 32'h8000_0100 + 32'(4*nb)};
            chk("pkt_data", o_out_tdata, exp_b);
            chk("pkt_last", o_out_tlast, (nb == 15) ? 1 : 0);
            nb++;
         end
      end
      i_msg_valid = 1'b0;
      chk("pkt_beat_count", nb, 16);

      // Backpressure: 8 messages fill output register and accumulator.
      i_out_tready = 1'b0;
      for (int k = 0; k < 8; k++) begin
         chk("bp_ready_open", o_msg_ready, 1);
         send_msg(32'h8000_0300 + 32'(k));
      end
      chk("bp_ready_closed", o_msg_ready, 0);
      held_b = {32'h8000_0303, 32'h8000_0302, 32'h8000_0301, 32'h8000_0300};
      chk("bp_held_data", o_out_tdata, held_b);
      repeat (3) tick();
      chk("bp_stable_data", o_out_tdata, held_b);
      chk("bp_stable_valid", o_out_tvalid, 1);
      i_out_tready = 1'b1;
      tick();
      chk("bp_second_valid", o_out_tvalid, 1);
      chk("bp_second_data", o_out_tdata, {32'h8000_0307, 32'h8000_0306, 32'h8000_0305, 32'h8000_0304});
      chk("bp_second_last", o_out_tlast, 0);
      chk("bp_ready_back", o_msg_ready, 1);
      tick();
      chk("bp_drained", o_out_tvalid, 0);
`ifdef NX_GEARBOX_COUNTERS_EN
      chk("cnt_in_pkts", o_cnt_in_pkts, 1);
      chk("cnt_out_pkts", o_cnt_out_pkts, 2);
      chk("cnt_drops", o_cnt_drops, 2);
`endif

      // Reset with a held output beat, a partial accumulator and a pending inbound message.
      i_out_tready = 1'b0;
      for (int k = 0; k < 6; k++) send_msg(32'h8000_0400 + 32'(k));
      i_msg_ready = 1'b0;
      i_in_tdata  = {96'h0, 32'h8000_0777};
      i_in_tvalid = 1'b1;
      tick();
      i_in_tvalid = 1'b0;
      chk("pre_rst_msg_valid", o_msg_valid, 1);
      chk("pre_rst_out_valid", o_out_tvalid, 1);
      i_rst = 1'b1;
      tick();
      chk("mid_rst_out_valid", o_out_tvalid, 0);
      chk("mid_rst_msg_valid", o_msg_valid, 0);
      chk("mid_rst_out_data", o_out_tdata, 0);
`ifdef NX_GEARBOX_COUNTERS_EN
      chk("mid_rst_cnt_out", o_cnt_out_pkts, 0);
      chk("mid_rst_cnt_drops", o_cnt_drops, 0);
`endif
      i_rst = 1'b0;
      i_out_tready = 1'b1;
      i_msg_ready = 1'b1;
      nv = 0;
      for (int c = 0; c < 100; c++) begin
         tick();
         if (o_out_tvalid || o_msg_valid) nv++;
      end
      chk("post_rst_quiet", nv, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
